aibio_rxdll_cal_fsm: RTL and testbench

//  Digital calibration/lock controller for the RX-side DLL, the receive counterpart of the TX DLL.

---
 rtl/aibio_rxdll_cal_fsm.sv | 143 ++++++++++++++
 tb/tb_aibio_rxdll_cal_fsm.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/aibio_rxdll_cal_fsm.sv
// rtl/aibio_rxdll_cal_fsm.sv - RX DLL calibration and lock controller
// Resets the DLL, servos the cap code on windowed phase-detector error, then tracks while locked.
module aibio_rxdll_cal_fsm #(
    parameter int WIN_W      = 8,
    parameter int CAP_W      = 5,
    parameter int SETTLE_CYC = 16
) (
    input  logic             i_clkin,
    input  logic             i_reset_n,
    input  logic             i_dll_en,
    input  logic             i_up,
    input  logic             i_dn,
    input  logic [3:0]       i_lockthresh,
    input  logic [1:0]       i_lockctrl,
    input  logic [CAP_W-1:0] i_cap_init,
    input  logic             i_cal_bypass,
    output logic [CAP_W-1:0] o_dll_capctrl,
    output logic             o_dll_reset,
    output logic             o_dll_lock,
    output logic             o_cal_err,
    output logic [2:0]       o_state
);

    localparam int ACC_W = WIN_W + 2;
    localparam int SET_W = $clog2(SETTLE_CYC) + 1;
    localparam int CNT_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(3);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'((1 << WIN_W) - 1);
    localparam logic [CAP_W-1:0] CAP_MID     = CAP_W'(1 << (CAP_W - 1));
    localparam logic [CAP_W-1:0] CAP_MAX     = '1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_MEAS   = 3'd3,
        ST_ADJ    = 3'd4,
        ST_LOCKED = 3'd5,
        ST_FAIL   = 3'd6
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [ACC_W-1:0]   r_acc;
    logic [3:0]                r_good;
    logic                      r_bypass;
    logic [CAP_W-1:0]          r_cap;

    logic signed [ACC_W-1:0]   w_delta;
    logic signed [ACC_W-1:0]   w_acc_sum;
    logic [ACC_W-1:0]          w_acc_abs;
    logic                      w_measuring;
    logic                      w_win_end;
    logic                      w_in_thr;
    logic                      w_in_trk;
    logic [3:0]                w_good_inc;
    logic [3:0]                w_need;
    logic                      w_adj_fail;

    // Window evaluation sees the sum including the current cycle's sample.
    assign w_delta     = (i_up & ~i_dn) ? ACC_W'(1) : ((i_dn & ~i_up) ? '1 : '0);
    assign w_acc_sum   = r_acc + w_delta;
    assign w_acc_abs   = w_acc_sum[ACC_W-1] ? ACC_W'(-w_acc_sum) : ACC_W'(w_acc_sum);
    assign w_measuring = (r_state == ST_MEAS) || (r_state == ST_LOCKED);
    assign w_win_end   = w_measuring && (r_cnt == WIN_LAST);
    assign w_in_thr    = w_acc_abs <= ACC_W'(i_lockthresh);
    assign w_in_trk    = w_acc_abs <= ACC_W'({i_lockthresh, 1'b0});
    assign w_good_inc  = r_good + 4'd1;
    assign w_need      = 4'd1 << i_lockctrl;
    assign w_adj_fail  = r_acc[ACC_W-1] ? (r_cap == CAP_MAX) : (r_cap == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (i_dll_en) w_state_nxt = ST_RST;
            ST_RST:    if (r_cnt == RST_LAST) w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_cnt == SETTLE_LAST) w_state_nxt = i_cal_bypass ? ST_LOCKED : ST_MEAS;
            ST_MEAS: begin
                if (w_win_end) begin
                    if (!w_in_thr)
                        w_state_nxt = ST_ADJ;
                    else if (w_good_inc >= w_need)
                        w_state_nxt = ST_LOCKED;
                end
            end
            ST_ADJ:    w_state_nxt = w_adj_fail ? ST_FAIL : ST_SETTLE;
            ST_LOCKED: if (!r_bypass && w_win_end && !w_in_trk) w_state_nxt = ST_ADJ;
            ST_FAIL:   w_state_nxt = ST_FAIL;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (!i_dll_en) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge i_clkin) begin
        if (!i_reset_n) begin
            r_state  <= ST_IDLE;
            r_cap    <= CAP_MID;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_good   <= '0;
            r_bypass <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_state_nxt != r_state || w_win_end || r_state == ST_IDLE || r_state == ST_FAIL)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);

            // The failing window's sum is kept through ADJ to pick the step direction.
            if (w_state_nxt == ST_ADJ)
                r_acc <= w_acc_sum;
            else if (w_measuring && !w_win_end && w_state_nxt == r_state)
                r_acc <= w_acc_sum;
            else
                r_acc <= '0;

            if (r_state == ST_MEAS && w_state_nxt == ST_MEAS)
                r_good <= w_win_end ? w_good_inc : r_good;
            else
                r_good <= '0;

            if (r_state == ST_IDLE && w_state_nxt == ST_RST)
                r_cap <= i_cap_init;
            else if (r_state == ST_ADJ && w_state_nxt == ST_SETTLE)
                r_cap <= r_acc[ACC_W-1] ? r_cap + CAP_W'(1) : r_cap - CAP_W'(1);

            if (w_state_nxt == ST_IDLE)
                r_bypass <= 1'b0;
            else if (r_state == ST_SETTLE && w_state_nxt != ST_SETTLE)
                r_bypass <= i_cal_bypass;
        end
    end

    assign o_dll_capctrl = r_cap;
    assign o_dll_reset   = (r_state == ST_IDLE) || (r_state == ST_RST);
    assign o_dll_lock    = (r_state == ST_LOCKED);
    assign o_cal_err     = (r_state == ST_FAIL);
    assign o_state       = r_state;

endmodule

// File: tb/tb_aibio_rxdll_cal_fsm.sv
// tb/tb_aibio_rxdll_cal_fsm.sv - self-checking bench for aibio_rxdll_cal_fsm
// Hand-written corner sequences followed by a table of plant-driven calibration runs.
module tb_aibio_rxdll_cal_fsm;

    localparam int ST_IDLE   = 0;
    localparam int ST_RST    = 1;
    localparam int ST_SETTLE = 2;
    localparam int ST_MEAS   = 3;
    localparam int ST_ADJ    = 4;
    localparam int ST_LOCKED = 5;
    localparam int ST_FAIL   = 6;
    localparam int WIN       = 256;
    localparam int SETTLE    = 16;
    localparam int STARTUP   = 1 + 4 + SETTLE;
    localparam int ADJ_COST  = WIN + 1 + SETTLE;
    localparam int BUDGET    = 3000;
    localparam int NVEC      = 8;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en;
    logic       up;
    logic       dn;
    logic [3:0] thr;
    logic [1:0] lc;
    logic [4:0] init;
    logic       byp;
    logic [4:0] capctrl;
    logic       dll_reset;
    logic       dll_lock;
    logic       cal_err;
    logic [2:0] state;

    always #5 clk = ~clk;

    aibio_rxdll_cal_fsm #(.WIN_W(8), .CAP_W(5), .SETTLE_CYC(16)) dut (
        .i_clkin       (clk),
        .i_reset_n     (resetn),
        .i_dll_en      (en),
        .i_up          (up),
        .i_dn          (dn),
        .i_lockthresh  (thr),
        .i_lockctrl    (lc),
        .i_cap_init    (init),
        .i_cal_bypass  (byp),
        .o_dll_capctrl (capctrl),
        .o_dll_reset   (dll_reset),
        .o_dll_lock    (dll_lock),
        .o_cal_err     (cal_err),
        .o_state       (state)
    );

    typedef struct {
        int thr; int lc; int init; int byp; int tgt;
        int cap; int lock; int err; int st; int edges;
    } vec_t;

    typedef struct {
        int cap; int lock; int err; int st; int edges;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic u, input logic d);
        up = u;
        dn = d;
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // Plant: phase detector reports up while the cap code is above the target, dn below it.
    task automatic step_plant(input int tgt);
        if (int'(capctrl) > tgt)
            step(1'b1, 1'b0);
        else if (int'(capctrl) < tgt)
            step(1'b0, 1'b1);
        else
            step(1'b0, 1'b0);
    endtask

    task automatic run_window(input int nu, input int nd, input int nb);
        for (int i = 0; i < WIN; i++) begin
            if (i < nu)                step(1'b1, 1'b0);
            else if (i < nu + nd)      step(1'b0, 1'b1);
            else if (i < nu + nd + nb) step(1'b1, 1'b1);
            else                       step(1'b0, 1'b0);
        end
    endtask

    initial begin
        int   edges;
        exp_t e;

        vecs[0] = '{2, 0, 10, 0, 10, 10, 1, 0, ST_LOCKED, STARTUP + WIN};
        vecs[1] = '{2, 0, 10, 0, 7,  7,  1, 0, ST_LOCKED, STARTUP + 3*ADJ_COST + WIN};
        vecs[2] = '{2, 0, 0,  0, -1, 0,  0, 1, ST_FAIL,   STARTUP + WIN + 1};
        vecs[3] = '{2, 0, 31, 0, 40, 31, 0, 1, ST_FAIL,   STARTUP + WIN + 1};
        vecs[4] = '{2, 1, 12, 0, 14, 14, 1, 0, ST_LOCKED, STARTUP + 2*ADJ_COST + 2*WIN};
        vecs[5] = '{2, 0, 20, 1, 0,  20, 1, 0, ST_LOCKED, STARTUP};
        vecs[6] = '{0, 2, 5,  0, 5,  5,  1, 0, ST_LOCKED, STARTUP + 4*WIN};
        vecs[7] = '{2, 0, 1,  0, 0,  0,  1, 0, ST_LOCKED, STARTUP + ADJ_COST + WIN};

        resetn = 1'b0; en = 1'b1; up = 1'b0; dn = 1'b0;
        thr = 4'd4; lc = 2'd0; init = 5'd9; byp = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("reset state", 32'(state), ST_IDLE);
        chk("reset capctrl", 32'(capctrl), 16);
        chk("reset dll_reset", 32'(dll_reset), 1);
        chk("reset lock", 32'(dll_lock), 0);
        chk("reset err", 32'(cal_err), 0);

        resetn = 1'b1;
        step(1'b0, 1'b0);
        chk("rst entry state", 32'(state), ST_RST);
        chk("rst entry cap_init load", 32'(capctrl), 9);
        chk("rst entry dll_reset", 32'(dll_reset), 1);
        idle_steps(3);
        chk("rst 4th cycle state", 32'(state), ST_RST);
        step(1'b0, 1'b0);
        chk("settle entry state", 32'(state), ST_SETTLE);
        chk("settle dll_reset", 32'(dll_reset), 0);
        idle_steps(SETTLE - 1);
        chk("settle last cycle state", 32'(state), ST_SETTLE);
        step(1'b0, 1'b0);
        chk("meas entry state", 32'(state), ST_MEAS);

        run_window(5, 0, 0);
        chk("acc above thresh state", 32'(state), ST_ADJ);
        step(1'b0, 1'b0);
        chk("adj decrement cap", 32'(capctrl), 8);
        chk("adj to settle state", 32'(state), ST_SETTLE);
        idle_steps(SETTLE);
        chk("resettle to meas", 32'(state), ST_MEAS);
        run_window(4, 0, 100);
        chk("acc equal thresh locks", 32'(state), ST_LOCKED);
        chk("locked lock out", 32'(dll_lock), 1);

        thr = 4'd3;
        run_window(5, 0, 0);
        chk("track acc 5 keeps lock", 32'(dll_lock), 1);
        run_window(7, 1, 0);
        chk("track acc 6 keeps lock", 32'(dll_lock), 1);
        run_window(7, 0, 0);
        chk("track acc 7 drops lock", 32'(dll_lock), 0);
        chk("track acc 7 state", 32'(state), ST_ADJ);
        step(1'b0, 1'b0);
        chk("track adj cap", 32'(capctrl), 7);
        idle_steps(SETTLE);
        chk("track resettle meas", 32'(state), ST_MEAS);

        for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
        en = 1'b0;
        step(1'b0, 1'b0);
        chk("en drop state", 32'(state), ST_IDLE);
        chk("en drop dll_reset", 32'(dll_reset), 1);
        chk("en drop cap hold", 32'(capctrl), 7);

        thr = 4'd2; lc = 2'd3; init = 5'd20; en = 1'b1;
        idle_steps(STARTUP);
        chk("lc3 meas entry", 32'(state), ST_MEAS);
        for (int w = 0; w < 7; w++) begin
            run_window(0, 0, 0);
            chk($sformatf("lc3 first run good %0d lock", w), 32'(dll_lock), 0);
        end
        run_window(0, 3, 0);
        chk("lc3 bad window state", 32'(state), ST_ADJ);
        step(1'b0, 1'b0);
        chk("lc3 adj increment cap", 32'(capctrl), 21);
        idle_steps(SETTLE);
        for (int w = 0; w < 7; w++) begin
            run_window(0, 0, 0);
            chk($sformatf("lc3 second run good %0d lock", w), 32'(dll_lock), 0);
        end
        run_window(0, 0, 0);
        chk("lc3 8th good lock", 32'(dll_lock), 1);
        en = 1'b0;
        step(1'b0, 1'b0);
        chk("lc3 disable state", 32'(state), ST_IDLE);

        for (int r = 0; r < NVEC; r++) begin
            thr  = 4'(vecs[r].thr);
            lc   = 2'(vecs[r].lc);
            init = 5'(vecs[r].init);
            byp  = 1'(vecs[r].byp);
            sb.push_back('{vecs[r].cap, vecs[r].lock, vecs[r].err, vecs[r].st, vecs[r].edges});
            en = 1'b1;
            edges = 0;
            while (!(dll_lock || cal_err) && edges < BUDGET) begin
                step_plant(vecs[r].tgt);
                edges++;
            end
            e = sb.pop_front();
            chk($sformatf("row%0d edges to done", r), 32'(edges), 32'(e.edges));
            chk($sformatf("row%0d cap", r), 32'(capctrl), 32'(e.cap));
            chk($sformatf("row%0d lock", r), 32'(dll_lock), 32'(e.lock));
            chk($sformatf("row%0d err", r), 32'(cal_err), 32'(e.err));
            chk($sformatf("row%0d state", r), 32'(state), 32'(e.st));
            for (int i = 0; i < 300; i++) step_plant(vecs[r].tgt);
            chk($sformatf("row%0d hold state", r), 32'(state), 32'(e.st));
            chk($sformatf("row%0d hold cap", r), 32'(capctrl), 32'(e.cap));
            en = 1'b0;
            step_plant(vecs[r].tgt);
            chk($sformatf("row%0d off state", r), 32'(state), ST_IDLE);
            chk($sformatf("row%0d off err", r), 32'(cal_err), 0);
            chk($sformatf("row%0d off lock", r), 32'(dll_lock), 0);
            chk($sformatf("row%0d off cap", r), 32'(capctrl), 32'(e.cap));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
